dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised data memory for the single-cycle/multi-cycle CPU datapath. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Access latency is configurable, and every request completes through a req/ready handshake. Misaligned accesses are detected and reported as faults. The block sits between the CPU memory stage and local storage.

## Interface
- DEPTH_LOG2, default 7: log2 of the number of 32-bit words (7 gives 128 words); the byte address width is DEPTH_LOG2+2.
- LATENCY, default 1: cycles from request acceptance to completion; legal range 1..15.
- INIT_FILE, default "": if non-empty, the memory is loaded with $readmemh at elaboration.
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  access request; sampled only while idle.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  DEPTH_LOG2+2  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, registered; holds its value between completions.
- ready  out  1  one-cycle completion pulse.
- fault  out  1  valid only with ready; 1 = misaligned or reserved access.
- busy  out  1  high while a request is in flight.

## Operation
- FSM states:
  - IDLE: busy=0.
  - WAIT: busy=1; a down-counter runs here.
  - DONE: busy=0; ready=1 for exactly one cycle.
- Acceptance: at a rising edge with state=IDLE and req=1, latch we, size, uns, addr and wdata.
- Misalignment check at acceptance:
  - size=01 with addr[0]=1 is a fault.
  - size=10 with addr[1:0]≠00 is a fault.
  - size=11 is always a fault.
  - A faulting request goes directly to DONE with fault=1. It performs no memory write, leaves rdata unchanged, and ignores LATENCY.
- Normal request: enter WAIT with the counter set to LATENCY-1. When the counter reaches 0, perform the access at the edge that enters DONE. With LATENCY=1 the block goes IDLE→DONE directly.
- Word index is addr[DEPTH_LOG2+1:2]; byte lane is addr[1:0]; byte order is little-endian.
- Stores:
  - Byte writes wdata[7:0] into lane addr[1:0] only.
  - Half writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word writes all 32 bits.
  - Lanes not written keep their contents.
- Loads:
  - Extract the selected byte or half.
  - If uns=0, extend with its MSB; if uns=1, extend with zeros.
  - The result is written into rdata at the edge entering DONE.
  - A store completion leaves rdata unchanged.
- DONE always returns to IDLE on the next edge. A new req can therefore be accepted no earlier than the cycle after ready.
- req while busy=1 or state=DONE is ignored; no queuing.
- Memory contents are not affected by reset.

## Timing
- Reset (rstn=0, asynchronous): state=IDLE, counter=0, rdata=0, ready=0, fault=0, busy=0.
- Reset during WAIT: the pending store is discarded with no write, and no ready is produced.
- Completion timing:
  - Normal request: ready high exactly LATENCY cycles after the acceptance edge.
  - Faulting request: ready high exactly 1 cycle after the acceptance edge.
- Minimum period between accepted requests is LATENCY+1 cycles.
- rdata is valid from the ready cycle until the next load completion.
- A load to the address of the immediately preceding store returns the stored data, because the write committed before the load was accepted.

## Test plan
- LATENCY=1, word store 0x12345678 at 0x010, then word load at 0x010 → ready 1 cycle after each acceptance; rdata=0x12345678, fault=0.
- Byte store 0xAB at 0x011, then:
  - word load at 0x010 → rdata=0x1234AB78;
  - signed byte load at 0x011 → 0xFFFFFFAB;
  - unsigned byte load at 0x011 → 0x000000AB.
- Half store 0x8001 at 0x012, then:
  - word load at 0x010 → 0x8001AB78;
  - signed half load at 0x012 → 0xFFFF8001;
  - unsigned half load at 0x012 → 0x00008001.
- Misaligned accesses, each checked separately:
  - word load at 0x013 → ready=1, fault=1 one cycle later; rdata unchanged;
  - half store at 0x011 → same fault response; word at 0x010 unchanged;
  - size=11 → fault.
- LATENCY=3 build:
  - busy=1 for 2 cycles, then ready on the 3rd cycle after acceptance;
  - req pulses with different addresses while busy produce no extra ready and no memory change.
- LATENCY=3, store 0xDEADBEEF at 0x020, then rstn=0 during WAIT:
  - all outputs become 0 immediately;
  - after release, a word load at 0x020 returns the prior contents, not 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/half/word data memory behind a req/ready handshake.
// Access latency is configurable; misaligned requests complete early as faults.
module dmem_ctrl #(
    parameter int DEPTH_LOG2 = 7,
    parameter int LATENCY    = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [DEPTH_LOG2+1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  fault,
    output logic                  busy
);

    localparam int AW = DEPTH_LOG2 + 2;
    localparam int NW = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t st_q, st_d;
    logic [3:0] cnt_q, cnt_d;

    logic          we_q, uns_q, flt_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          bad_in, go;
    logic          a_we, a_uns;
    logic [1:0]    a_size;
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;

    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           word, sh, wd, ld;
    logic [3:0]            be;

    logic [31:0] mem [0:NW-1];

    always_comb begin
        bad_in = (size == 2'b11) ||
                 (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);
    end

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        go    = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (req) begin
                    if (bad_in) begin
                        st_d = DONE;
                    end else if (LATENCY == 1) begin
                        st_d = DONE;
                        go   = 1'b1;
                    end else begin
                        st_d  = WAIT;
                        cnt_d = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    st_d = DONE;
                    go   = 1'b1;
                end
            end
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q  <= IDLE;
            cnt_q <= 4'd0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            flt_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (st_q == IDLE && req) begin
            we_q    <= we;
            uns_q   <= uns;
            flt_q   <= bad_in;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Single-cycle builds access straight from the request inputs.
    always_comb begin
        if (st_q == IDLE) begin
            a_we    = we;
            a_uns   = uns;
            a_size  = size;
            a_addr  = addr;
            a_wdata = wdata;
        end else begin
            a_we    = we_q;
            a_uns   = uns_q;
            a_size  = size_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
        end
    end

    assign idx  = a_addr[AW-1:2];
    assign word = mem[idx];
    assign sh   = word >> {a_addr[1:0], 3'b000};

    always_comb begin
        be = 4'b1111;
        wd = a_wdata;
        ld = word;
        unique case (a_size)
            2'b00: begin
                be = 4'b0001 << a_addr[1:0];
                wd = {4{a_wdata[7:0]}};
                ld = {{24{~a_uns & sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                be = a_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{a_wdata[15:0]}};
                ld = {{16{~a_uns & sh[15]}}, sh[15:0]};
            end
            default: begin
                be = 4'b1111;
                wd = a_wdata;
                ld = word;
            end
        endcase
    end

    // Storage has no reset; rstn gating drops a store caught by reset.
    always_ff @(posedge clk) begin
        if (go && a_we && rstn) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= 32'd0;
        end else if (go && !a_we) begin
            rdata <= ld;
        end
    end

    assign ready = (st_q == DONE);
    assign fault = (st_q == DONE) & flt_q;
    assign busy  = (st_q == WAIT);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: LATENCY=1 and LATENCY=3 instances checked against
// a byte-array reference model with directed and random accesses.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rstn1, rstn3, req1, req3;
    logic        we, uns;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3, fault1, fault3, busy1, busy3;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mm [2][512];
    logic [31:0] last [2];

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_LOG2(7), .LATENCY(1)) u1 (
        .clk(clk), .rstn(rstn1), .req(req1), .we(we), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .rdata(rdata1),
        .ready(ready1), .fault(fault1), .busy(busy1)
    );

    dmem_ctrl #(.DEPTH_LOG2(7), .LATENCY(3)) u3 (
        .clk(clk), .rstn(rstn3), .req(req3), .we(we), .size(size),
        .uns(uns), .addr(addr), .wdata(wdata), .rdata(rdata3),
        .ready(ready3), .fault(fault3), .busy(busy3)
    );

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        f;
    } op_t;

    // Reference: memory as a byte array, loads assembled little-endian.
    task automatic ref_op(input int d, input logic w, input logic [1:0] sz,
                          input logic u, input logic [8:0] a,
                          input logic [31:0] wd, output logic [31:0] er,
                          output logic ef, output int el);
        int k, nb;
        logic [31:0] v;
        k  = (d == 3) ? 1 : 0;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ef = (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) ||
             (sz == 2'b10 && a % 4 != 0);
        el = ef ? 1 : d;
        if (!ef) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mm[k][a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++)
                    v = v | (32'(mm[k][a + i]) << (8 * i));
                if (!u && nb < 4 && v[8*nb-1])
                    v = v | (32'hFFFF_FFFF << (8 * nb));
                last[k] = v;
            end
        end
        er = last[k];
    endtask

    task automatic access(input int d, input logic w, input logic [1:0] sz,
                          input logic u, input logic [8:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic flt, output int lat, output int bc);
        @(negedge clk);
        we = w; size = sz; uns = u; addr = a; wdata = wd;
        if (d == 3) req3 = 1'b1;
        else        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        req3 = 1'b0;
        lat  = 1;
        bc   = 0;
        while (!(d == 3 ? ready3 : ready1) && lat < 20) begin
            if (d == 3 ? busy3 : busy1) bc++;
            @(negedge clk);
            lat++;
        end
        rd  = (d == 3) ? rdata3 : rdata1;
        flt = (d == 3) ? fault3 : fault1;
    endtask

    task automatic test_reset;
        rstn1 = 1'b0; rstn3 = 1'b0;
        req1 = 1'b0; req3 = 1'b0;
        we = 1'b0; uns = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        checks += 8;
        if (ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b want 0", ready1); end
        if (fault1 !== 1'b0) begin errors++; $display("FAIL rst_fault1 got %b want 0", fault1); end
        if (busy1 !== 1'b0)  begin errors++; $display("FAIL rst_busy1 got %b want 0", busy1); end
        if (rdata1 !== 32'd0) begin errors++; $display("FAIL rst_rdata1 got %h want 0", rdata1); end
        if (ready3 !== 1'b0) begin errors++; $display("FAIL rst_ready3 got %b want 0", ready3); end
        if (fault3 !== 1'b0) begin errors++; $display("FAIL rst_fault3 got %b want 0", fault3); end
        if (busy3 !== 1'b0)  begin errors++; $display("FAIL rst_busy3 got %b want 0", busy3); end
        if (rdata3 !== 32'd0) begin errors++; $display("FAIL rst_rdata3 got %h want 0", rdata3); end
        rstn1 = 1'b1; rstn3 = 1'b1;
        last[0] = 32'd0;
        last[1] = 32'd0;
    endtask

    task automatic test_directed;
        op_t t[14];
        logic [31:0] rd, er;
        logic flt, ef;
        int lat, bc, el;
        t[0]  = '{1'b1, 2'b10, 1'b0, 9'h010, 32'h1234_5678, 32'h0000_0000, 1'b0};
        t[1]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,         32'h1234_5678, 1'b0};
        t[2]  = '{1'b1, 2'b00, 1'b0, 9'h011, 32'h0000_00AB, 32'h1234_5678, 1'b0};
        t[3]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,         32'h1234_AB78, 1'b0};
        t[4]  = '{1'b0, 2'b00, 1'b0, 9'h011, 32'h0,         32'hFFFF_FFAB, 1'b0};
        t[5]  = '{1'b0, 2'b00, 1'b1, 9'h011, 32'h0,         32'h0000_00AB, 1'b0};
        t[6]  = '{1'b1, 2'b01, 1'b0, 9'h012, 32'h0000_8001, 32'h0000_00AB, 1'b0};
        t[7]  = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,         32'h8001_AB78, 1'b0};
        t[8]  = '{1'b0, 2'b01, 1'b0, 9'h012, 32'h0,         32'hFFFF_8001, 1'b0};
        t[9]  = '{1'b0, 2'b01, 1'b1, 9'h012, 32'h0,         32'h0000_8001, 1'b0};
        t[10] = '{1'b0, 2'b10, 1'b0, 9'h013, 32'h0,         32'h0000_8001, 1'b1};
        t[11] = '{1'b1, 2'b01, 1'b0, 9'h011, 32'hFFFF_FFFF, 32'h0000_8001, 1'b1};
        t[12] = '{1'b0, 2'b10, 1'b0, 9'h010, 32'h0,         32'h8001_AB78, 1'b0};
        t[13] = '{1'b0, 2'b11, 1'b0, 9'h010, 32'h0,         32'h8001_AB78, 1'b1};
        for (int i = 0; i < 14; i++) begin
            access(1, t[i].w, t[i].sz, t[i].u, t[i].a, t[i].d, rd, flt, lat, bc);
            ref_op(1, t[i].w, t[i].sz, t[i].u, t[i].a, t[i].d, er, ef, el);
            checks += 3;
            if (lat != 1) begin
                errors++; $display("FAIL dir%0d_latency got %0d want 1", i, lat);
            end
            if (flt !== t[i].f) begin
                errors++; $display("FAIL dir%0d_fault got %b want %b", i, flt, t[i].f);
            end
            if (rd !== t[i].exp) begin
                errors++; $display("FAIL dir%0d_rdata got %h want %h", i, rd, t[i].exp);
            end
        end
    endtask

    task automatic test_latency3;
        logic [31:0] rd, er;
        logic flt, ef;
        int lat, bc, el;
        access(3, 1'b1, 2'b10, 1'b0, 9'h020, 32'h1122_3344, rd, flt, lat, bc);
        ref_op(3, 1'b1, 2'b10, 1'b0, 9'h020, 32'h1122_3344, er, ef, el);
        checks += 3;
        if (lat != 3) begin errors++; $display("FAIL l3_st_latency got %0d want 3", lat); end
        if (bc != 2)  begin errors++; $display("FAIL l3_st_busy got %0d want 2", bc); end
        if (flt !== 1'b0) begin errors++; $display("FAIL l3_st_fault got %b want 0", flt); end
        access(3, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, rd, flt, lat, bc);
        ref_op(3, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, er, ef, el);
        checks += 3;
        if (lat != 3) begin errors++; $display("FAIL l3_ld_latency got %0d want 3", lat); end
        if (bc != 2)  begin errors++; $display("FAIL l3_ld_busy got %0d want 2", bc); end
        if (rd !== 32'h1122_3344) begin
            errors++; $display("FAIL l3_ld_rdata got %h want 11223344", rd);
        end
        access(3, 1'b0, 2'b10, 1'b0, 9'h023, 32'h0, rd, flt, lat, bc);
        checks += 2;
        if (lat != 1) begin errors++; $display("FAIL l3_flt_latency got %0d want 1", lat); end
        if (flt !== 1'b1) begin errors++; $display("FAIL l3_flt_fault got %b want 1", flt); end
    endtask

    task automatic test_ignore_busy;
        logic [31:0] rd, er;
        logic flt, ef;
        int lat, bc, el, n;
        access(3, 1'b1, 2'b10, 1'b0, 9'h030, 32'h0A0A_0A0A, rd, flt, lat, bc);
        ref_op(3, 1'b1, 2'b10, 1'b0, 9'h030, 32'h0A0A_0A0A, er, ef, el);
        access(3, 1'b1, 2'b10, 1'b0, 9'h038, 32'h5555_AAAA, rd, flt, lat, bc);
        ref_op(3, 1'b1, 2'b10, 1'b0, 9'h038, 32'h5555_AAAA, er, ef, el);
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 9'h034;
        wdata = 32'hB0B0_B0B0; req3 = 1'b1;
        @(negedge clk);
        n = int'(ready3);
        addr = 9'h030; wdata = 32'hC0C0_C0C0;
        @(negedge clk);
        n += int'(ready3);
        addr = 9'h038; wdata = 32'hD0D0_D0D0;
        @(negedge clk);
        n += int'(ready3);
        req3 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n += int'(ready3);
        end
        ref_op(3, 1'b1, 2'b10, 1'b0, 9'h034, 32'hB0B0_B0B0, er, ef, el);
        checks++;
        if (n != 1) begin errors++; $display("FAIL ign_ready_count got %0d want 1", n); end
        for (int i = 0; i < 3; i++) begin
            logic [8:0] a;
            a = 9'h030 + 9'(4 * i);
            access(3, 1'b0, 2'b10, 1'b0, a, 32'h0, rd, flt, lat, bc);
            ref_op(3, 1'b0, 2'b10, 1'b0, a, 32'h0, er, ef, el);
            checks++;
            if (rd !== er) begin
                errors++; $display("FAIL ign_word%0d got %h want %h", i, rd, er);
            end
        end
    endtask

    task automatic test_reset_wait;
        logic [31:0] rd, er;
        logic flt, ef;
        int lat, bc, el;
        @(negedge clk);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 9'h020;
        wdata = 32'hDEAD_BEEF; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        checks++;
        if (busy3 !== 1'b1) begin errors++; $display("FAIL rw_busy_before got %b want 1", busy3); end
        #2 rstn3 = 1'b0;
        #1;
        checks += 4;
        if (ready3 !== 1'b0) begin errors++; $display("FAIL rw_ready got %b want 0", ready3); end
        if (fault3 !== 1'b0) begin errors++; $display("FAIL rw_fault got %b want 0", fault3); end
        if (busy3 !== 1'b0)  begin errors++; $display("FAIL rw_busy got %b want 0", busy3); end
        if (rdata3 !== 32'd0) begin errors++; $display("FAIL rw_rdata got %h want 0", rdata3); end
        @(negedge clk);
        rstn3 = 1'b1;
        last[1] = 32'd0;
        access(3, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, rd, flt, lat, bc);
        ref_op(3, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, er, ef, el);
        checks += 2;
        if (lat != 3) begin errors++; $display("FAIL rw_ld_latency got %0d want 3", lat); end
        if (rd !== 32'h1122_3344) begin
            errors++; $display("FAIL rw_ld_rdata got %h want 11223344", rd);
        end
    endtask

    task automatic test_random(input int d);
        logic [31:0] rd, er, wd;
        logic flt, ef, w, u;
        logic [1:0] sz;
        logic [8:0] a;
        int lat, bc, el;
        for (int i = 0; i < 32; i++) begin
            a  = 9'h100 + 9'(4 * i);
            wd = $urandom;
            access(d, 1'b1, 2'b10, 1'b0, a, wd, rd, flt, lat, bc);
            ref_op(d, 1'b1, 2'b10, 1'b0, a, wd, er, ef, el);
            checks++;
            if (lat != el) begin
                errors++; $display("FAIL rnd%0d_init%0d_latency got %0d want %0d", d, i, lat, el);
            end
        end
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 9'h100 + 9'($urandom_range(0, 127));
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            wd = $urandom;
            access(d, w, sz, u, a, wd, rd, flt, lat, bc);
            ref_op(d, w, sz, u, a, wd, er, ef, el);
            checks += 3;
            if (lat != el) begin
                errors++; $display("FAIL rnd%0d_op%0d_latency got %0d want %0d", d, i, lat, el);
            end
            if (flt !== ef) begin
                errors++; $display("FAIL rnd%0d_op%0d_fault got %b want %b", d, i, flt, ef);
            end
            if (rd !== er) begin
                errors++; $display("FAIL rnd%0d_op%0d_rdata got %h want %h", d, i, rd, er);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_latency3;
        test_ignore_busy;
        test_reset_wait;
        test_random(1);
        test_random(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
